// File: rtl/nand9_tester.sv
// nand9_tester: exhaustive stimulus generator and response checker for an
// N-input NAND gate. It walks vec_out from 0 to all-ones and holds each
// vector for SETTLE_CYCLES clocks. It then samples y_in against ~&vec_out
// and counts the mismatches.
// Optional build macro: NAND9_TESTER_FAIL_CAPTURE_EN adds capture of the
// first failing vector on fail_valid/fail_vec.
//
// state  | meaning
// IDLE   | waiting for the first start after reset
// SETTLE | current vector held while the gate output settles
// SAMPLE | y_in compared against the expected NAND value
// DONE   | sweep finished, results held until the next start
module nand9_tester #(
  parameter int N             = 9,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         y_in,
  output logic [N-1:0] vec_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic         fail_valid,
  output logic [N-1:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [N-1:0] vec_d;
  logic [N:0]   err_d;
  logic         busy_d, done_d;
  logic         start_go, mismatch;

  assign start_go = start && ((state_q == IDLE) || (state_q == DONE));
  assign mismatch = (y_in != ~&vec_out);
  assign pass     = done && (err_count == '0);

  // State and datapath registers; everything clears asynchronously on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      vec_out   <= '0;
      err_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vec_out   <= vec_d;
      err_count <= err_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state and next-register logic. The defaults hold every register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_out;
    err_d   = err_count;
    busy_d  = busy;
    done_d  = done;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SETTLE;
          vec_d   = '0;
          err_d   = '0;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      SAMPLE: begin
        if (mismatch) err_d = err_count + (N+1)'(1);
        // The sweep stops at all-ones instead of letting vec_out wrap.
        if (&vec_out) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = SETTLE;
          vec_d   = vec_out + N'(1);
          cnt_d   = CNT_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef NAND9_TESTER_FAIL_CAPTURE_EN
  logic         fail_valid_q;
  logic [N-1:0] fail_vec_q;

  // Capture the first mismatching vector of a sweep. Later mismatches do not
  // overwrite it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else if (start_go) begin
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else if ((state_q == SAMPLE) && mismatch && !fail_valid_q) begin
      fail_valid_q <= 1'b1;
      fail_vec_q   <= vec_out;
    end
  end

  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
`else
  assign fail_valid = 1'b0;
  assign fail_vec   = '0;
`endif

endmodule

// File: tb/tb_nand9_tester.sv
// Bench for nand9_tester. The stimulus process issues sweeps and pushes the
// expected results into a queue. A monitor pops an entry whenever done rises
// and compares it with the DUT outputs.
module tb_nand9_tester;

  typedef struct {
    int         err;
    logic       pass;
    logic       fv;
    logic [8:0] fvec;
    int         cycles;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start8 = 1'b0;
  logic       y_in, y8;
  int         mode = 0;
  logic [8:0] vec_out, vec8;
  logic       busy, done, pass, busy8, done8, pass8;
  logic [9:0] err_count, err8;
  logic       fail_valid, fv8;
  logic [8:0] fail_vec, fvec8;
  logic [8:0] pipe [6] = '{default: '0};
  logic [8:0] pipe8 [6] = '{default: '0};

  int   n_pass = 0, n_total = 0;
  int   cyc = 0, start_cyc = 0;
  exp_t sb [$];
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  nand9_tester #(.N(9), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in), .vec_out(vec_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_vec(fail_vec));

  nand9_tester #(.N(9), .SETTLE_CYCLES(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .y_in(y8), .vec_out(vec8),
    .busy(busy8), .done(done8), .pass(pass8), .err_count(err8),
    .fail_valid(fv8), .fail_vec(fvec8));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pipe[0]  <= vec_out;
    pipe8[0] <= vec8;
    for (int k = 1; k < 6; k++) begin
      pipe[k]  <= pipe[k-1];
      pipe8[k] <= pipe8[k-1];
    end
  end

  // Gate models: 0 ideal, 1 stuck at 1, 2 stuck at 0, 3 six-cycle delay.
  always_comb begin
    y_in = ~&vec_out;
    case (mode)
      1: y_in = 1'b1;
      2: y_in = 1'b0;
      3: y_in = ~&pipe[5];
      default: y_in = ~&vec_out;
    endcase
    y8 = ~&pipe8[5];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t mk(int err, logic fv, logic [8:0] fvec);
    exp_t e;
    e.err    = err;
    e.pass   = (err == 0);
`ifdef NAND9_TESTER_FAIL_CAPTURE_EN
    e.fv     = fv;
    e.fvec   = fvec;
`else
    e.fv     = 1'b0;
    e.fvec   = 9'h000;
`endif
    e.cycles = 2560;
    return e;
  endfunction

  // Monitor: on each rising edge of done, check the results against the next
  // queued expectation.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sweep_cycles", cyc - start_cyc, e.cycles);
        chk("err_count", int'(err_count), e.err);
        chk("pass", int'(pass), int'(e.pass));
        chk("vec_out_end", int'(vec_out), 'h1FF);
        chk("busy_end", int'(busy), 0);
        chk("fail_valid", int'(fail_valid), int'(e.fv));
        chk("fail_vec", int'(fail_vec), int'(e.fvec));
      end
    end
    done_prev = done;
  end

  task automatic go(input exp_t e);
    sb.push_back(e);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", int'(done), 1);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #1;
    chk("rst_vec", int'(vec_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_fv", int'(fail_valid), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Ideal gate with extra start pulses while busy, which must be ignored.
    mode = 0;
    go(mk(0, 1'b0, 9'h000));
    chk("busy_after_start", int'(busy), 1);
    for (int p = 0; p < 4; p++) begin
      repeat (200) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    wait_done();

    // Output stuck at 1, started from DONE.
    mode = 1;
    go(mk(1, 1'b1, 9'h1FF));
    chk("done_fell", int'(done), 0);
    chk("busy_restart", int'(busy), 1);
    chk("vec_restart", int'(vec_out), 0);
    chk("err_cleared", int'(err_count), 0);
    wait_done();

    // Output stuck at 0.
    mode = 2;
    go(mk(511, 1'b1, 9'h000));
    wait_done();

    // Asynchronous reset in the middle of a sweep.
    mode = 0;
    go(mk(0, 1'b0, 9'h000));
    begin
      int n = 0;
      while (vec_out != 9'h0A3 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("reach_0A3", int'(vec_out), 'h0A3);
    end
    void'(sb.pop_back());
    #1 rst = 1'b1;
    #1;
    chk("arst_vec", int'(vec_out), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_err", int'(err_count), 0);
    @(negedge clk) rst = 1'b0;
    go(mk(0, 1'b0, 9'h000));
    wait_done();

    // Six-cycle gate delay with SETTLE_CYCLES=4. Each sample sees the previous
    // vector, so vector 0 (vs 0x1FF) and 0x1FF (vs 0x1FE) both fail.
    mode = 3;
    go(mk(2, 1'b1, 9'h000));
    wait_done();

    // The same delay with SETTLE_CYCLES=8 gives a clean 4608-cycle sweep.
    begin
      int s8, n;
      @(negedge clk) start8 = 1'b1;
      @(negedge clk) start8 = 1'b0;
      s8 = cyc;
      n = 0;
      while (!done8 && n < 6000) begin
        @(negedge clk);
        n++;
      end
      chk("s8_cycles", cyc - s8, 4608);
      chk("s8_err", int'(err8), 0);
      chk("s8_pass", int'(pass8), 1);
    end

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
